// File: rtl/text_buffer.sv
// text_buffer: character-terminal screen memory.
// Bytes from the keyboard stage are written at the cursor. The buffer handles
// carriage return, backspace, line wrap and scrolling. Scrolling rotates a
// circular row offset (top) rather than moving data, so only the newly exposed
// bottom line has to be blanked. The renderer reads through a registered port
// that is indexed by logical row/column.
module text_buffer #(
  parameter int COLS  = 70,
  parameter int ROWS  = 30,
  parameter int COL_W = 7,
  parameter int ROW_W = 5
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             key_valid,
  input  logic [7:0]       key_ascii,
  output logic             key_ready,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
  output logic [7:0]       rd_ascii,
  output logic [COL_W-1:0] cur_col,
  output logic [ROW_W-1:0] cur_row,
  output logic             busy
);

  localparam int DEPTH  = ROWS * COLS;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  // Map a logical row onto a physical RAM row: (row + top) mod ROWS.
  // Both operands are below ROWS, so a single compare-and-subtract suffices.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lrow,
                                                input logic [ROW_W-1:0] top);
    logic [ROW_W:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= (ROW_W+1)'(ROWS)) begin
      sum = sum - (ROW_W+1)'(ROWS);
    end
    return sum[ROW_W-1:0];
  endfunction

  // Flat RAM address of (physical row, column).
  function automatic logic [ADDR_W-1:0] row_addr(input logic [ROW_W-1:0] prow,
                                                 input logic [COL_W-1:0] col);
    return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  logic [7:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;          // INIT address counter
  logic [COL_W-1:0]  clr_col_q, clr_col_d;  // CLEAR column counter
  logic [ROW_W-1:0]  clr_row_q, clr_row_d;  // physical row being blanked
  logic [ROW_W-1:0]  top_q, top_d;          // physical row shown at logical row 0
  logic [COL_W-1:0]  cur_col_q, cur_col_d;
  logic [ROW_W-1:0]  cur_row_q, cur_row_d;
  logic [7:0]        rd_ascii_q;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic              newline;
  logic [ROW_W-1:0]  cur_phys;

  logic [ROW_W-1:0]  rd_phys;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_in_range;

  assign cur_phys = phys_row(cur_row_q, top_q);

  // Next-state, cursor/scroll update and RAM write-port control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_col_d = clr_col_q;
    clr_row_d = clr_row_q;
    top_d     = top_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    we        = 1'b0;
    waddr     = '0;
    wdata     = CH_SPACE;
    newline   = 1'b0;
    key_ready = 1'b0;
    busy      = 1'b1;

    case (state_q)
      S_INIT: begin
        // Blank the whole screen, one cell per cycle, by physical address.
        we    = 1'b1;
        waddr = cnt_q;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CLEAR: begin
        // Blank the physical row that just became the bottom line.
        we    = 1'b1;
        waddr = row_addr(clr_row_q, clr_col_q);
        if (clr_col_q == LAST_COL) begin
          clr_col_d = '0;
          state_d   = S_IDLE;
        end else begin
          clr_col_d = clr_col_q + 1'b1;
        end
      end

      S_IDLE: begin
        key_ready = 1'b1;
        busy      = 1'b0;
        if (key_valid) begin
          if (key_ascii >= CH_SPACE && key_ascii <= CH_TILDE) begin
            we    = 1'b1;
            waddr = row_addr(cur_phys, cur_col_q);
            wdata = key_ascii;
            if (cur_col_q == LAST_COL) begin
              cur_col_d = '0;
              newline   = 1'b1;
            end else begin
              cur_col_d = cur_col_q + 1'b1;
            end
          end else if (key_ascii == CH_CR) begin
            cur_col_d = '0;
            newline   = 1'b1;
          end else if (key_ascii == CH_BS) begin
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - 1'b1;
              we        = 1'b1;
              waddr     = row_addr(cur_phys, cur_col_q - 1'b1);
            end else if (cur_row_q != '0) begin
              cur_row_d = cur_row_q - 1'b1;
              cur_col_d = LAST_COL;
              we        = 1'b1;
              waddr     = row_addr(phys_row(cur_row_q - 1'b1, top_q), LAST_COL);
            end
          end
          // Any other code is consumed without effect.

          if (newline) begin
            if (cur_row_q != LAST_ROW) begin
              cur_row_d = cur_row_q + 1'b1;
            end else begin
              // Scroll: the old top line becomes the new bottom line.
              top_d     = (top_q == LAST_ROW) ? '0 : top_q + 1'b1;
              clr_row_d = top_q;
              clr_col_d = '0;
              state_d   = S_CLEAR;
            end
          end
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Control and cursor state; reset restarts the screen initialisation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      clr_col_q <= '0;
      clr_row_q <= '0;
      top_q     <= '0;
      cur_col_q <= '0;
      cur_row_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_col_q <= clr_col_d;
      clr_row_q <= clr_row_d;
      top_q     <= top_d;
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
    end
  end

  // Screen RAM write port; contents are not reset (INIT blanks them).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd_in_range = (rd_col <= LAST_COL) && (rd_row <= LAST_ROW);
  assign rd_phys     = phys_row(rd_row, top_q);
  assign rd_addr     = row_addr(rd_phys, rd_col);

  // Registered renderer read; uses the current top so scrolls show at once,
  // and a same-edge write returns the old cell contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ascii_q <= 8'h00;
    end else if (rd_in_range) begin
      rd_ascii_q <= mem[rd_addr];
    end else begin
      rd_ascii_q <= 8'h00;
    end
  end

  assign rd_ascii = rd_ascii_q;
  assign cur_col  = cur_col_q;
  assign cur_row  = cur_row_q;

endmodule
